// File: rtl/ui_cond_pkg.sv
// Shared constants for the ui_in conditioning path: debounce depth and the
// controller field layout carried on the debounced bus.
package ui_cond_pkg;

    localparam int unsigned DB_CYCLES_DEFAULT = 4;

    localparam int unsigned FIELD_W = 2;
    localparam int unsigned G1_LSB  = 0;
    localparam int unsigned G2_LSB  = 2;
    localparam int unsigned A_LSB   = 4;
    localparam int unsigned P_LSB   = 6;

    typedef enum logic [1:0] {
        FLD_G1 = 2'd0,
        FLD_G2 = 2'd1,
        FLD_A  = 2'd2,
        FLD_P  = 2'd3
    } ui_field_e;

    function automatic int unsigned field_lsb(input ui_field_e f);
        return int'(f) * FIELD_W;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer, stability counter, debounced level
// and single-cycle rise/fall pulses.
module debounce_bit
    import ui_cond_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic pulse_d
);

    localparam int unsigned     CNT_W   = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    generate
        if (DB_CYCLES < 1) begin : g_bad_cfg
            $error("debounce_bit: DB_CYCLES must be at least 1");
        end
    endgenerate

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (ena) begin
            // A sample matching the current level discards any partial progress.
            if (s2_q == q_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                q_d    = s2_q;
                cnt_d  = '0;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            q_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q       = q_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    // Next-state event lets the parent register its summary in step with the pulses.
    assign pulse_d = rise_d | fall_d;

endmodule

// File: rtl/ui_debounce.sv
// Debounces WIDTH independent raw inputs and registers an any-edge flag
// coincident with the per-bit rise/fall pulses.
module ui_debounce
    import ui_cond_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] pulse_d;
    logic             changed_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .DB_CYCLES(DB_CYCLES)
            ) u_bit (
                .clk    (clk),
                .rst_n  (rst_n),
                .ena    (ena),
                .d      (din[gi]),
                .q      (dout[gi]),
                .rise   (rise[gi]),
                .fall   (fall[gi]),
                .pulse_d(pulse_d[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |pulse_d;
        end
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_ui_debounce.sv
// Directed bench for ui_debounce: a run-length reference model checked every
// cycle, plus hand-computed literal checkpoints for each scenario.
module tb_ui_debounce;

    localparam int unsigned W  = 8;
    localparam int unsigned DB = 4;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    int n_cmp;
    int n_bad;

    ui_debounce #(
        .WIDTH    (W),
        .DB_CYCLES(DB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .din    (din),
        .dout   (dout),
        .rise   (rise),
        .fall   (fall),
        .changed(changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: din delayed two edges is the sample; a bit flips once it has
    // seen DB consecutive enabled samples different from its level.
    logic [W-1:0] m_h0, m_h1, m_dout, m_rise, m_fall;
    int unsigned  m_run [W];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h0   <= '0;
            m_h1   <= '0;
            m_dout <= '0;
            m_rise <= '0;
            m_fall <= '0;
            for (int i = 0; i < W; i++) m_run[i] <= 0;
        end else begin
            m_h0 <= din;
            m_h1 <= m_h0;
            for (int i = 0; i < W; i++) begin
                m_rise[i] <= 1'b0;
                m_fall[i] <= 1'b0;
                if (!ena) begin
                    m_run[i] <= m_run[i];
                end else if (m_h1[i] != m_dout[i]) begin
                    if (m_run[i] + 1 == DB) begin
                        m_dout[i] <= m_h1[i];
                        m_rise[i] <= m_h1[i];
                        m_fall[i] <= ~m_h1[i];
                        m_run[i]  <= 0;
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                    end
                end else begin
                    m_run[i] <= 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("model dout", dout, m_dout);
        chk("model rise", rise, m_rise);
        chk("model fall", fall, m_fall);
        chk("model changed", {7'b0, changed}, {7'b0, |(m_rise | m_fall)});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cmp_model();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        ena   = 1'b1;
        din   = 8'hFF;
        #1 rst_n = 1'b0;
        @(negedge clk);

        // Reset hold with all inputs high
        steps(2);
        chk("rst dout", dout, 8'h00);
        chk("rst changed", {7'b0, changed}, 8'h00);
        rst_n = 1'b1;
        steps(5);
        chk("hold dout pre", dout, 8'h00);
        step();
        chk("hold dout", dout, 8'hFF);
        chk("hold rise", rise, 8'hFF);
        chk("hold changed", {7'b0, changed}, 8'h01);
        step();
        chk("hold rise gone", rise, 8'h00);
        chk("hold changed gone", {7'b0, changed}, 8'h00);

        din = 8'h00;
        steps(8);
        chk("all low", dout, 8'h00);

        // Clean step on bit 0
        din = 8'h01;
        steps(5);
        chk("step dout pre", dout, 8'h00);
        step();
        chk("step dout", dout, 8'h01);
        chk("step rise", rise, 8'h01);
        din = 8'h00;
        steps(5);
        chk("step fall pre", dout, 8'h01);
        step();
        chk("step fall dout", dout, 8'h00);
        chk("step fall", fall, 8'h01);
        steps(3);

        // Glitch of 3 cycles rejected, 4 cycles accepted
        din = 8'h08;
        steps(3);
        din = 8'h00;
        steps(10);
        chk("glitch dout", dout, 8'h00);
        din = 8'h08;
        steps(4);
        din = 8'h00;
        step();
        chk("min pulse pre", dout, 8'h00);
        step();
        chk("min pulse dout", dout, 8'h08);
        chk("min pulse rise", rise, 8'h08);
        steps(8);
        chk("min pulse back", dout, 8'h00);

        // Enable freeze after two counted samples
        din = 8'h20;
        steps(4);
        ena = 1'b0;
        steps(10);
        chk("freeze dout", dout, 8'h00);
        ena = 1'b1;
        step();
        chk("freeze resume pre", dout, 8'h00);
        step();
        chk("freeze dout", dout, 8'h20);
        chk("freeze rise", rise, 8'h20);
        din = 8'h00;
        steps(8);

        // Multi-bit simultaneous change
        din = 8'hA5;
        steps(5);
        chk("multi pre", dout, 8'h00);
        step();
        chk("multi dout", dout, 8'hA5);
        chk("multi rise", rise, 8'hA5);
        chk("multi changed", {7'b0, changed}, 8'h01);
        din = 8'h5A;
        steps(5);
        step();
        chk("swap dout", dout, 8'h5A);
        chk("swap rise", rise, 8'h5A);
        chk("swap fall", fall, 8'hA5);
        chk("swap changed", {7'b0, changed}, 8'h01);
        steps(2);

        // Reset mid-count on bit 7
        din = 8'hDA;
        steps(4);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst dout", dout, 8'h00);
        chk("async rst rise", rise, 8'h00);
        chk("async rst fall", fall, 8'h00);
        din = 8'h80;
        steps(3);
        rst_n = 1'b1;
        steps(5);
        chk("rst mid pre", dout, 8'h00);
        step();
        chk("rst mid dout", dout, 8'h80);
        chk("rst mid rise", rise, 8'h80);
        step();
        chk("rst mid rise gone", rise, 8'h00);
        steps(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
